// File: rtl/scariv_bru_brtag_ctrl_pkg.sv
// Brtag pool configuration and shared types for the BRU brtag controller slice.
// scariv_conf_pkg holds the pool size, scariv_bru_pkg the tag/pointer types and helpers.
package scariv_conf_pkg;
    localparam int unsigned BRTAG_SIZE = 16;
endpackage

package scariv_bru_pkg;
    import scariv_conf_pkg::*;

    localparam int unsigned BRTAG_W = $clog2(BRTAG_SIZE);

    typedef logic [BRTAG_W-1:0] brtag_t;
    typedef logic [BRTAG_W:0]   brtag_cnt_t;

    // Tag index plus wrap bit; the wrap bit tells full from empty.
    typedef struct packed {
        logic   wrap;
        brtag_t tag;
    } brtag_ptr_t;

    // Number of set bits in mask[k-1:0].
    function automatic brtag_cnt_t prefix_popcnt(input logic [31:0] mask, input int unsigned k);
        brtag_cnt_t cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < k && mask[i]) begin
                cnt = cnt + brtag_cnt_t'(1);
            end
        end
        return cnt;
    endfunction
endpackage

// File: rtl/scariv_bru_brtag_ctrl_if.sv
// Dispatch/BRU-facing signal bundle of the brtag controller.
// master = dispatch/BRU side, slave = brtag controller.
interface scariv_bru_brtag_ctrl_if
    import scariv_conf_pkg::*;
    import scariv_bru_pkg::*;
#(
    parameter int unsigned ALLOC_W = 2
) ();
    logic                       i_alloc_valid;
    logic [ALLOC_W-1:0]         i_alloc_mask;
    logic                       o_alloc_ready;
    brtag_t [ALLOC_W-1:0]       o_alloc_tag;
    logic                       i_resolve_valid;
    brtag_t                     i_resolve_tag;
    logic                       i_resolve_mispred;
    logic                       i_flush_all;
    logic [BRTAG_SIZE-1:0]      o_live_mask;
    brtag_cnt_t                 o_free_cnt;
    logic [31:0]                o_stat_stall_cnt;
    logic [31:0]                o_stat_squash_cnt;

    modport master (
        output i_alloc_valid, i_alloc_mask,
        output i_resolve_valid, i_resolve_tag, i_resolve_mispred, i_flush_all,
        input  o_alloc_ready, o_alloc_tag, o_live_mask, o_free_cnt,
        input  o_stat_stall_cnt, o_stat_squash_cnt
    );

    modport slave (
        input  i_alloc_valid, i_alloc_mask,
        input  i_resolve_valid, i_resolve_tag, i_resolve_mispred, i_flush_all,
        output o_alloc_ready, o_alloc_tag, o_live_mask, o_free_cnt,
        output o_stat_stall_cnt, o_stat_squash_cnt
    );
endinterface

// File: rtl/scariv_bru_brtag_ctrl_retire_scan.sv
// In-order retire scan: counts the contiguous run of resolved live tags starting at rd_ptr.
module scariv_brtag_retire_scan
    import scariv_conf_pkg::*;
    import scariv_bru_pkg::*;
#(
    parameter int unsigned RETIRE_W = 2
) (
    input  logic [BRTAG_SIZE-1:0] i_resolved,
    input  brtag_t                i_rd_tag,
    input  brtag_cnt_t            i_count,
    output brtag_cnt_t            o_retire_cnt
);
    logic   stop;
    brtag_t idx;

    always_comb begin
        o_retire_cnt = '0;
        stop         = 1'b0;
        idx          = '0;
        for (int unsigned i = 0; i < RETIRE_W; i++) begin
            idx = i_rd_tag + brtag_t'(i);
            if (!stop && (brtag_cnt_t'(i) < i_count) && i_resolved[idx]) begin
                o_retire_cnt = o_retire_cnt + brtag_cnt_t'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scariv_bru_brtag_ctrl.sv
// Branch tag pool owner: in-order allocation, out-of-order resolve, in-order retire, mispredict squash.
// Optional statistics counters are built when SCARIV_BRTAG_STATS_EN is defined.
module scariv_bru_brtag_ctrl
    import scariv_conf_pkg::*;
    import scariv_bru_pkg::*;
#(
    parameter int unsigned ALLOC_W  = 2,
    parameter int unsigned RETIRE_W = 2
) (
    input logic                    i_clk,
    input logic                    i_reset_n,
    scariv_bru_brtag_ctrl_if.slave bus
);
    brtag_ptr_t            wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    brtag_cnt_t            count, count_nxt, alloc_n, scan_n, retire_n;
    brtag_cnt_t            res_off_ext, mis_ptr, free_q;
    brtag_t                res_off;
    logic [BRTAG_SIZE-1:0] resolved, resolved_nxt, live_nxt, live_q;
    logic                  res_live, mis_req, mis_apply, alloc_ready, fire;
    brtag_t [ALLOC_W-1:0]  alloc_tag;

    assign count       = brtag_cnt_t'(wr_ptr) - brtag_cnt_t'(rd_ptr);
    assign alloc_n     = prefix_popcnt(32'(bus.i_alloc_mask), ALLOC_W);
    assign mis_req     = bus.i_resolve_valid & bus.i_resolve_mispred;
    assign alloc_ready = ((32'(count) + 32'(alloc_n)) <= BRTAG_SIZE) && !bus.i_flush_all && !mis_req;
    assign fire        = bus.i_alloc_valid & alloc_ready;

    // Age of the resolved tag relative to the oldest live tag.
    assign res_off     = bus.i_resolve_tag - rd_ptr.tag;
    assign res_off_ext = {1'b0, res_off};
    assign res_live    = res_off_ext < count;
    assign mis_apply   = mis_req & res_live & !bus.i_flush_all;
    assign mis_ptr     = brtag_cnt_t'(rd_ptr) + res_off_ext;

    always_comb begin
        alloc_tag = '0;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            alloc_tag[k] = wr_ptr.tag + brtag_t'(prefix_popcnt(32'(bus.i_alloc_mask), k));
        end
    end

    scariv_brtag_retire_scan #(
        .RETIRE_W (RETIRE_W)
    ) u_retire_scan (
        .i_resolved   (resolved),
        .i_rd_tag     (rd_ptr.tag),
        .i_count      (count),
        .o_retire_cnt (scan_n)
    );

    // A mispredicted tag that was already resolved must not let retire run past it.
    assign retire_n = (mis_apply && (scan_n > res_off_ext + brtag_cnt_t'(1))) ?
                      res_off_ext + brtag_cnt_t'(1) : scan_n;

    always_comb begin
        brtag_t off;
        rd_nxt       = rd_ptr;
        wr_nxt       = wr_ptr;
        resolved_nxt = resolved;
        off          = '0;
        if (bus.i_flush_all) begin
            rd_nxt       = '0;
            wr_nxt       = '0;
            resolved_nxt = '0;
        end else begin
            rd_nxt = brtag_ptr_t'(brtag_cnt_t'(rd_ptr) + retire_n);
            if (mis_apply) begin
                wr_nxt = brtag_ptr_t'(mis_ptr + brtag_cnt_t'(1));
            end else if (fire) begin
                wr_nxt = brtag_ptr_t'(brtag_cnt_t'(wr_ptr) + alloc_n);
            end
            if (bus.i_resolve_valid && res_live) begin
                resolved_nxt[bus.i_resolve_tag] = 1'b1;
            end
            for (int unsigned i = 0; i < BRTAG_SIZE; i++) begin
                off = brtag_t'(i) - rd_ptr.tag;
                if ({1'b0, off} < retire_n) begin
                    resolved_nxt[i] = 1'b0;
                end
                if (mis_apply && (off > res_off) && ({1'b0, off} < count)) begin
                    resolved_nxt[i] = 1'b0;
                end
                if (fire && ({1'b0, off} >= count) && ({1'b0, off} < count + alloc_n)) begin
                    resolved_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_nxt = brtag_cnt_t'(wr_nxt) - brtag_cnt_t'(rd_nxt);
        live_nxt  = '0;
        for (int unsigned i = 0; i < BRTAG_SIZE; i++) begin
            live_nxt[i] = {1'b0, brtag_t'(brtag_t'(i) - rd_nxt.tag)} < count_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            resolved <= '0;
            live_q   <= '0;
            free_q   <= brtag_cnt_t'(BRTAG_SIZE);
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            resolved <= resolved_nxt;
            live_q   <= live_nxt;
            free_q   <= brtag_cnt_t'(BRTAG_SIZE) - count_nxt;
        end
    end

    assign bus.o_alloc_ready = alloc_ready;
    assign bus.o_alloc_tag   = alloc_tag;
    assign bus.o_live_mask   = live_q;
    assign bus.o_free_cnt    = free_q;

`ifdef SCARIV_BRTAG_STATS_EN
    logic [31:0] stall_cnt, squash_cnt;
    brtag_cnt_t  squash_n;

    assign squash_n = count - res_off_ext - brtag_cnt_t'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (bus.i_alloc_valid && !alloc_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (mis_apply) begin
                squash_cnt <= (squash_cnt > ('1 - 32'(squash_n))) ? '1 : squash_cnt + 32'(squash_n);
            end
        end
    end

    assign bus.o_stat_stall_cnt  = stall_cnt;
    assign bus.o_stat_squash_cnt = squash_cnt;
`else
    assign bus.o_stat_stall_cnt  = '0;
    assign bus.o_stat_squash_cnt = '0;
`endif

    resolve_live_a: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (bus.i_resolve_valid && !bus.i_flush_all) |-> res_live);
endmodule
